// File: rtl/sipo_6bit_rx.sv
// sipo_6bit_rx: serial-in/parallel-out receiver for an LSB-first (or MSB-first)
// serial link. Accumulates WIDTH bits under a bit strobe, hands each completed
// word to a holding register with a valid/ready handshake, and flags a sticky
// overrun when a completed word arrives while the held word is still unread.
module sipo_6bit_rx #(
  parameter int unsigned WIDTH     = 6,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     serial_in,
  input  logic                     shift_en,
  input  logic                     sync,
  input  logic                     word_ready,
  input  logic                     ovr_clr,
  output logic [WIDTH-1:0]         q_parallel_out,
  output logic                     word_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sr_base;
  logic [CW-1:0]    cnt_base;
  logic             complete;

  // Shift register and bit counter next state; sync restarts the frame before
  // the current bit (if any) is shifted in, so that bit opens the new frame.
  always_comb begin
    sr_base  = sync ? '0 : sr_q;
    cnt_base = sync ? '0 : cnt_q;
    complete = shift_en && !sync && (cnt_q == LAST_BIT);
    sr_d     = sr_base;
    cnt_d    = cnt_base;
    if (shift_en) begin
      if (MSB_FIRST) begin
        sr_d = {sr_base[WIDTH-2:0], serial_in};
      end else begin
        sr_d = {serial_in, sr_base[WIDTH-1:1]};
      end
      cnt_d = complete ? '0 : cnt_base + CW'(1);
    end
  end

  // Holding register, handshake and sticky overrun next state.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q && !ovr_clr;
    if (complete) begin
      if (!valid_q || word_ready) begin
        hold_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q_parallel_out = hold_q;
  assign word_valid     = valid_q;
  assign overrun        = ovr_q;
  assign bit_count      = cnt_q;

endmodule
